out_fm_tile_ctrl: RTL
=====================

# out_fm_tile_ctrl

Tile-level sequencer for the output feature-map buffer (`output_fm`). For each output tile it runs three phases in order: load partial sums into the four out_fm banks, run one convolution pass per input-channel tile, then store the result. It sits between the top-level layer controller and the `output_fm`/conv datapath, and drives their `*_start` pulses from their `*_done` pulses. It also carries a per-phase watchdog so a stalled FIFO cannot hang the layer silently.

## Interface
Parameters:
- CW, 16, width of tile counters and tile indices
- TO_W, 24, width of the watchdog counter
- TO_MAX, 24'hFF_FFFF, watchdog limit in cycles per wait phase

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous and active-low
- start  in  1  layer start pulse from top controller
- out_tile_num  in  CW  number of output tiles; latched on accepted start
- in_tile_num  in  CW  input-channel tiles per output tile; latched on accepted start
- skip_ld  in  1  1 = skip the load phase (banks zero/bias-initialised); latched on accepted start
- busy  out  1  high from the cycle after an accepted start until the done or timeout cycle (exclusive)
- done  out  1  one-cycle pulse after the last store completes
- timeout  out  1  sticky; set when the watchdog expires, cleared on the next accepted start
- out_tile_idx  out  CW  current output tile, 0-based
- in_tile_idx  out  CW  current input-channel tile, 0-based
- out_fm_ld_start  out  1  one-cycle pulse to `output_fm` load
- out_fm_ld_done  in  1  load complete pulse
- conv_start  out  1  one-cycle pulse to compute array
- conv_done  in  1  compute pass complete pulse
- out_fm_st_start  out  1  one-cycle pulse to `output_fm` store
- out_fm_st_done  in  1  store complete pulse

## Operation
- FSM states: IDLE, LD, LD_W, CV, CV_W, ST, ST_W, FIN.
- IDLE:
  - Accept `start` only here. On an accepted start, latch the configuration, zero both indices and clear `timeout`.
  - If `out_tile_num==0` or `in_tile_num==0`, go to FIN. Otherwise go to ST-free path: LD, or CV if `skip_ld`.
- Issue states LD, CV, ST:
  - Each lasts exactly one cycle and asserts its own start output only.
  - Each then moves to the matching wait state: LD→LD_W, CV→CV_W, ST→ST_W.
- LD_W: on `out_fm_ld_done`, go to CV.
- CV_W: on `conv_done`:
  - If `in_tile_idx==in_tile_num-1`, go to ST.
  - Otherwise increment `in_tile_idx` and go to CV.
- ST_W: on `out_fm_st_done`:
  - If `out_tile_idx==out_tile_num-1`, go to FIN.
  - Otherwise increment `out_tile_idx`, zero `in_tile_idx`, and go to LD (or CV if `skip_ld`).
- FIN: assert `done` for one cycle, then go to IDLE. Indices hold their final values.
- Done inputs are sampled only in their own wait state. They are ignored in every other state, including a `*_done` arriving during an issue state.
- `start` while busy is ignored; latched configuration is unaffected.
- Watchdog:
  - Counter cleared on entering any wait state; increments each cycle in a wait state, saturating.
  - On reaching TO_MAX, set `timeout` and go to IDLE; `done` is not pulsed.
- All outputs are registered.
- Reset values: state IDLE; busy, done, timeout, all start outputs 0; indices 0.
- Reset mid-operation aborts at once with no done pulse. The datapath is responsible for its own reset.
- Index comparisons are at CW bits; `num-1` is computed at CW bits and is never evaluated when num is 0.

## Timing
- `start` sampled at edge E → LD (or CV) entered at E; `out_fm_ld_start`/`conv_start` high during cycle E+1; `busy` high from E+1.
- Each done→next-start hop is 1 cycle: done sampled at edge D → next start pulse high in cycle D+1.
- Last `out_fm_st_done` at edge D → `done` high in cycle D+1, `busy` low in cycle D+1, IDLE accepts `start` from edge D+1.
- Zero-tile start at E → `done` in cycle E+1; no start pulses at all.
- Timeout: `timeout` goes high and `busy` goes low in the same cycle.
- Minimum cycles per output tile (all done responses instant): 2 (LD) + 2·in_tile_num (CV) + 2 (ST).

## Structure
- Shared package `cnn_accel_pkg`:
  - state enum `otc_state_t`
  - default CW, TO_W and TO_MAX constants
- Natural sub-module: `phase_watchdog` (clear, run, saturating count, expire flag), reusable by the `input_fm`/weight load controllers.
- Otherwise a single FSM plus two index counters.

## Test plan
- `out_tile_num=2, in_tile_num=3, skip_ld=0`, datapath model answering each start after 5 cycles:
  - 2 ld_start, 6 conv_start, 2 st_start, in order LD,CV,CV,CV,ST per tile.
  - One `done`; `in_tile_idx` seen as 0,1,2,0,1,2.
- `skip_ld=1, out_tile_num=3, in_tile_num=1`: zero `out_fm_ld_start` pulses; 3 conv_start / 3 st_start alternating; done after third st_done +1 cycle.
- `out_tile_num=0`: `done` exactly 1 cycle after start; no start pulses; `busy` high for 0 cycles.
- `start` re-pulsed during CV_W, plus a spurious `out_fm_st_done` injected in CV_W: both ignored; pulse counts unchanged.
- `TO_MAX=16`, `conv_done` never returned: `timeout=1` and `busy=0` 16 cycles after entering CV_W; no `done`; next `start` clears `timeout`.
- rst asserted low during ST_W: all outputs 0 asynchronously; after release, new start runs a full clean sequence.

Source files
------------

// File: rtl/cnn_accel_pkg.sv
// rtl/cnn_accel_pkg.sv - shared types and defaults for the CNN accelerator tile controllers
package cnn_accel_pkg;

    localparam int unsigned OTC_CW     = 16;
    localparam int unsigned OTC_TO_W   = 24;
    localparam logic [23:0] OTC_TO_MAX = 24'hFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LD,
        LD_W,
        CV,
        CV_W,
        ST,
        ST_W,
        FIN
    } otc_state_t;

    // Issue states last one cycle and always lead into their wait state.
    function automatic logic otc_is_issue(input otc_state_t s);
        return (s == LD) || (s == CV) || (s == ST);
    endfunction

    function automatic logic otc_is_wait(input otc_state_t s);
        return (s == LD_W) || (s == CV_W) || (s == ST_W);
    endfunction

endpackage

// File: rtl/out_fm_tile_ctrl_if.sv
// rtl/out_fm_tile_ctrl_if.sv - layer-controller and datapath handshake bundle for out_fm_tile_ctrl
interface out_fm_tile_ctrl_if import cnn_accel_pkg::*; #(
    parameter int unsigned CW = OTC_CW
);

    logic          start;
    logic [CW-1:0] out_tile_num;
    logic [CW-1:0] in_tile_num;
    logic          skip_ld;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] out_tile_idx;
    logic [CW-1:0] in_tile_idx;
    logic          out_fm_ld_start;
    logic          out_fm_ld_done;
    logic          conv_start;
    logic          conv_done;
    logic          out_fm_st_start;
    logic          out_fm_st_done;

    // Controller side: takes commands and done pulses, issues start pulses.
    modport slave (
        input  start, out_tile_num, in_tile_num, skip_ld,
        input  out_fm_ld_done, conv_done, out_fm_st_done,
        output busy, done, timeout, out_tile_idx, in_tile_idx,
        output out_fm_ld_start, conv_start, out_fm_st_start
    );

    modport master (
        output start, out_tile_num, in_tile_num, skip_ld,
        output out_fm_ld_done, conv_done, out_fm_st_done,
        input  busy, done, timeout, out_tile_idx, in_tile_idx,
        input  out_fm_ld_start, conv_start, out_fm_st_start
    );

endinterface

// File: rtl/phase_watchdog.sv
// rtl/phase_watchdog.sv - saturating per-phase stall counter with expire flag
module phase_watchdog import cnn_accel_pkg::*; #(
    parameter int unsigned   W     = OTC_TO_W,
    parameter logic [W-1:0]  LIMIT = W'(OTC_TO_MAX)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    // LIMIT must be at least 1; expire fires on the edge where the count would reach LIMIT.
    localparam logic [W-1:0] LAST = LIMIT - W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && !clear_i && (cnt_q >= LAST);

endmodule

// File: rtl/out_fm_tile_ctrl.sv
// rtl/out_fm_tile_ctrl.sv - output-tile sequencer: load, per-input-tile conv passes, store, with watchdog
module out_fm_tile_ctrl import cnn_accel_pkg::*; #(
    parameter int unsigned      CW     = OTC_CW,
    parameter int unsigned      TO_W   = OTC_TO_W,
    parameter logic [TO_W-1:0]  TO_MAX = TO_W'(OTC_TO_MAX)
) (
    input  logic                 clk,
    input  logic                 rst,
    out_fm_tile_ctrl_if.slave    bus
);

    otc_state_t    state_q, state_d;
    logic [CW-1:0] out_num_q, out_num_d;
    logic [CW-1:0] in_num_q, in_num_d;
    logic          skip_q, skip_d;
    logic [CW-1:0] out_idx_q, out_idx_d;
    logic [CW-1:0] in_idx_q, in_idx_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, done_q;
    logic          ld_start_q, conv_start_q, st_start_q;
    logic [CW-1:0] in_last, out_last;
    logic          wd_expire;

    // Only reachable from wait states, which require both counts to be non-zero.
    assign in_last  = in_num_q - CW'(1);
    assign out_last = out_num_q - CW'(1);

    phase_watchdog #(
        .W     (TO_W),
        .LIMIT (TO_MAX)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (otc_is_issue(state_q)),
        .run_i    (otc_is_wait(state_q)),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        out_num_d = out_num_q;
        in_num_d  = in_num_q;
        skip_d    = skip_q;
        out_idx_d = out_idx_q;
        in_idx_d  = in_idx_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    out_num_d = bus.out_tile_num;
                    in_num_d  = bus.in_tile_num;
                    skip_d    = bus.skip_ld;
                    out_idx_d = '0;
                    in_idx_d  = '0;
                    timeout_d = 1'b0;
                    if ((bus.out_tile_num == '0) || (bus.in_tile_num == '0)) begin
                        state_d = FIN;
                    end else begin
                        state_d = bus.skip_ld ? CV : LD;
                    end
                end
            end
            LD: state_d = LD_W;
            CV: state_d = CV_W;
            ST: state_d = ST_W;
            LD_W: begin
                if (bus.out_fm_ld_done) begin
                    state_d = CV;
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            CV_W: begin
                if (bus.conv_done) begin
                    if (in_idx_q == in_last) begin
                        state_d = ST;
                    end else begin
                        in_idx_d = in_idx_q + CW'(1);
                        state_d  = CV;
                    end
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_W: begin
                if (bus.out_fm_st_done) begin
                    if (out_idx_q == out_last) begin
                        state_d = FIN;
                    end else begin
                        out_idx_d = out_idx_q + CW'(1);
                        in_idx_d  = '0;
                        state_d   = skip_q ? CV : LD;
                    end
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            out_num_q    <= '0;
            in_num_q     <= '0;
            skip_q       <= 1'b0;
            out_idx_q    <= '0;
            in_idx_q     <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ld_start_q   <= 1'b0;
            conv_start_q <= 1'b0;
            st_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_num_q    <= out_num_d;
            in_num_q     <= in_num_d;
            skip_q       <= skip_d;
            out_idx_q    <= out_idx_d;
            in_idx_q     <= in_idx_d;
            timeout_q    <= timeout_d;
            busy_q       <= (state_d != IDLE) && (state_d != FIN);
            done_q       <= (state_d == FIN);
            ld_start_q   <= (state_d == LD);
            conv_start_q <= (state_d == CV);
            st_start_q   <= (state_d == ST);
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.timeout         = timeout_q;
    assign bus.out_tile_idx    = out_idx_q;
    assign bus.in_tile_idx     = in_idx_q;
    assign bus.out_fm_ld_start = ld_start_q;
    assign bus.conv_start      = conv_start_q;
    assign bus.out_fm_st_start = st_start_q;

endmodule
